sr_flag_reader: RTL
===================

Name: sr_flag_reader

Overview:
- Synchronous consumer side for set/reset status flags.
- Per-channel event pulses set sticky pending flags; a downstream reader drains them one at a time over a valid/ready handshake, and each acceptance resets the served flag.
- Channels are selected round-robin, so no channel starves.
- Repeat events on a flag that is already pending are recorded in per-channel overflow bits.

Parameters:
- N, 8, number of flag channels (1..64).
- IDXW, (N>1 ? $clog2(N) : 1), width of the channel index (derived; not for override).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- aresetn  input  1  asynchronous active-low reset.
- set  input  N  event pulses; set[i]=1 in a cycle marks channel i pending.
- clr_overflow  input  1  clears all overflow bits.
- valid  output  1  idx holds a pending channel for the reader.
- ready  input  1  reader accepts idx when valid=1.
- idx  output  IDXW  channel being presented.
- pending  output  N  registered sticky flags.
- overflow  output  N  registered overflow flags.

Behaviour:
- Reset (aresetn=0, asynchronous):
  - pending=0, overflow=0, valid=0, idx=0.
  - Round-robin pointer ptr=0.
  - Every output is registered.
- Handshake: accept = valid & ready.
  - While valid=1 and ready=0, valid and idx hold stable.
  - ready has no effect when valid=0.
- pending[i] next state = set[i] | (pending[i] & ~(accept & idx==i)).
  - Set wins over a same-cycle clear: the channel stays pending and is not overflow.
- overflow[i] next state = (set[i] & pending[i] & ~(accept & idx==i)) | (overflow[i] & ~clr_overflow).
  - A new event wins over clr_overflow in the same cycle.
- State machine, two states:
  - IDLE (valid=0):
    - If pending != 0, choose c = first pending channel searching ptr, ptr+1, ... N-1, 0, ... (wrap-around).
    - Set idx=c, valid=1 next cycle, go to PRESENT.
    - Only registered pending is searched, so set is visible on valid 2 cycles after assertion.
  - PRESENT (valid=1):
    - On accept, ptr=idx+1 (wraps from N-1 to 0).
    - Search the next-state pending vector, excluding channel idx, starting from idx+1.
    - If a channel is found: idx=it, valid stays 1, stay in PRESENT. This gives back-to-back one grant per cycle.
    - If none is found: valid=0, go to IDLE. This applies even if idx itself was re-set this cycle; it is served from IDLE afterwards.
    - Without accept: hold.
- Invariants:
  - valid=1 implies pending[idx]=1.
  - idx < N always.
  - When N=1: idx is constant 0 and round-robin degenerates.
- Latency:
  - set-to-valid: 2 cycles from IDLE.
  - accept-to-pending-clear: 1 cycle.
- Reset mid-handshake: valid drops immediately; all flags are lost. No partial state survives.
- Accept and set on other channels in the same cycle are independent; all updates are applied together.

Test Plan:
- Reset, N=8, set=8'h00 for 5 cycles -> valid=0, pending=0, overflow=0, idx=0.
- set=8'b0001_0100 one cycle, ready=1 -> valid=1 with idx=2 at cycle 2, idx=4 at cycle 3, valid=0 at cycle 4; pending=0 afterwards.
- ready=0, set[5] pulsed then set[5] again 3 cycles later -> valid=1, idx=5 held stable; overflow[5]=1; pulse clr_overflow -> overflow=0, pending[5] still 1.
- Round-robin: hold set=8'hFF every cycle, ready=1 -> idx sequence 0,1,2,...,7,0,1 with valid continuously 1; no overflow on accepted channels (set wins over clear); overflow[i]=1 only for channels re-set while waiting.
- Simultaneous set[3] and accept of idx=3, no other pending -> next cycle valid=0, pending[3]=1, overflow[3]=0; valid=1 with idx=3 one cycle later.
- aresetn asserted asynchronously mid-cycle while valid=1, idx=6 -> valid, pending, overflow go to 0 without a clock edge; after release with set=0 -> valid stays 0.

Source files
------------

// File: rtl/sr_flag_reader.sv
// Set/reset status flag consumer: event pulses latch sticky pending flags, which a reader
// drains one channel at a time over valid/ready, picked round-robin.
module sr_flag_reader #(
    parameter int N = 8,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [N-1:0]    set,
    input  logic            clr_overflow,
    output logic            valid,
    input  logic            ready,
    output logic [IDXW-1:0] idx,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]      state_q;
    logic [IDXW-1:0] ptr_q;
    logic            accept;
    logic [N-1:0]    idx_onehot;
    logic [N-1:0]    clr_vec;
    logic [N-1:0]    pending_nx;
    logic [N-1:0]    overflow_nx;
    logic [IDXW-1:0] idx_inc;
    logic            idle_found;
    logic [IDXW-1:0] idle_sel;
    logic            next_found;
    logic [IDXW-1:0] next_sel;

    // First set bit of vec scanning start, start+1, ... with wrap; returns {found, index}.
    function automatic logic [IDXW:0] rr_pick(input logic [N-1:0] vec, input logic [IDXW-1:0] start);
        logic            found;
        logic [IDXW-1:0] sel;
        logic [IDXW-1:0] cand;
        int              j;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            cand = IDXW'(j);
            if (!found && vec[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return {found, sel};
    endfunction

    assign valid = (state_q == PRESENT);

    always_comb begin
        accept = valid & ready;
        for (int i = 0; i < N; i++) begin
            idx_onehot[i] = (idx == IDXW'(i));
        end
        clr_vec     = accept ? idx_onehot : '0;
        pending_nx  = set | (pending & ~clr_vec);
        overflow_nx = (set & pending & ~clr_vec) | (overflow & ~{N{clr_overflow}});
        idx_inc     = (idx == IDXW'(N - 1)) ? '0 : idx + 1'b1;
        {idle_found, idle_sel} = rr_pick(pending, ptr_q);
        // The channel just served is excluded even if re-set; IDLE picks it up later.
        {next_found, next_sel} = rr_pick(pending_nx & ~idx_onehot, idx_inc);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx      <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= pending_nx;
            overflow <= overflow_nx;
            case (state_q)
                IDLE: begin
                    if (idle_found) begin
                        idx     <= idle_sel;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        ptr_q <= idx_inc;
                        if (next_found) begin
                            idx <= next_sel;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
